// File: rtl/qpsk_modulator.sv
// QPSK modulator: mixes a free-running carrier with its quarter-period-delayed copy,
// signed by the I/Q bits of the current symbol, one output sample per clock.
module qpsk_modulator #(
    parameter int W      = 11,
    parameter int SPS    = 100,
    parameter int QDELAY = 25
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic signed [W-1:0] sin_in,
    input  logic [1:0]          sym_in,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic signed [W:0]   mod_out,
    output logic                mod_valid,
    output logic                underrun,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a symbol transfers on a rising Clk edge where sym_valid and sym_ready
    // are both high; sym_ready depends only on state and samp_cnt, never on sym_valid.

    localparam int FILL_W = $clog2(QDELAY + 1);
    localparam int SAMP_W = $clog2(SPS);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(QDELAY - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPS - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [1:0]          sym_q, sym_d;
    logic signed [W:0]   mod_out_q, mod_out_d;
    logic                mod_valid_q, mod_valid_d;
    logic                underrun_q, underrun_d;
    logic                ready;
    logic signed [W-1:0] dly_q [QDELAY];

    logic signed [W-1:0] q_car;
    logic signed [W:0]   car_ext, sin_ext, i_term, q_term, mod_next;

    assign q_car   = dly_q[QDELAY-1];
    assign car_ext = {q_car[W-1], q_car};
    assign sin_ext = {sin_in[W-1], sin_in};
    // Bit value 1 selects -1; one extra bit of headroom keeps the sum from wrapping.
    assign i_term   = sym_q[1] ? -car_ext : car_ext;
    assign q_term   = sym_q[0] ? -sin_ext : sin_ext;
    assign mod_next = i_term + q_term;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < QDELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= sin_in;
            for (int i = 1; i < QDELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            sym_q       <= '0;
            mod_out_q   <= '0;
            mod_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            sym_q       <= sym_d;
            mod_out_q   <= mod_out_d;
            mod_valid_q <= mod_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        sym_d       = sym_q;
        mod_out_d   = '0;
        mod_valid_d = 1'b0;
        underrun_d  = 1'b0;
        ready       = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d    = ST_WAIT;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                end
            end
            ST_WAIT: begin
                ready = 1'b1;
                if (sym_valid) begin
                    sym_d      = sym_in;
                    samp_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // The boundary sample is still built from the old symbol held in sym_q.
                mod_out_d   = mod_next;
                mod_valid_d = 1'b1;
                if (samp_cnt_q == SAMP_LAST) begin
                    ready      = 1'b1;
                    samp_cnt_d = '0;
                    if (sym_valid) begin
                        sym_d = sym_in;
                    end else begin
                        state_d    = ST_WAIT;
                        underrun_d = 1'b1;
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign sym_ready   = ready;
    assign mod_out     = mod_out_q;
    assign mod_valid   = mod_valid_q;
    assign underrun    = underrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qpsk_modulator.sv
// Bench for qpsk_modulator: a cycle driver keeps a reference of the handshake and
// carrier delay, pushes expected samples to a queue, and a negedge monitor pops them.
module tb_qpsk_modulator;

    localparam int W      = 11;
    localparam int SPS    = 100;
    localparam int QDELAY = 25;
    localparam int MODE_RAMP  = 0;
    localparam int MODE_CONST = 1;
    localparam int MODE_RAND  = 2;

    logic                Clk = 1'b0;
    logic                Rst_n = 1'b0;
    logic signed [W-1:0] sin_in = '0;
    logic [1:0]          sym_in = '0;
    logic                sym_valid = 1'b0;
    logic                sym_ready;
    logic signed [W:0]   mod_out;
    logic                mod_valid;
    logic                underrun;
    logic [1:0]          dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int mode = MODE_RAND;
    int k = 0;
    logic mon_en = 1'b0;

    // Reference state for the handshake and quadrature delay.
    int         m_fill = QDELAY;
    logic       m_run = 1'b0;
    int         m_left = 0;
    logic [1:0] m_sym = '0;
    logic       m_ready = 1'b0;
    logic       m_underrun = 1'b0;
    int         hist[$];
    logic signed [W:0] exp_q[$];

    qpsk_modulator #(.W(W), .SPS(SPS), .QDELAY(QDELAY)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .sin_in(sin_in), .sym_in(sym_in),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .mod_out(mod_out),
        .mod_valid(mod_valid), .underrun(underrun), .dbg_state_o(dbg_state)
    );

    always #5 Clk = ~Clk;

    function automatic logic signed [W:0] exp_mod(input logic [1:0] sy, input int qc, input int s);
        int i_t;
        int q_t;
        i_t = sy[1] ? -qc : qc;
        q_t = sy[0] ? -s : s;
        return (W+1)'(i_t + q_t);
    endfunction

    task automatic tick(input logic [1:0] sy, input logic v, output logic acc,
                        output logic smp, output logic [1:0] used, output int s);
        int qc;
        case (mode)
            MODE_RAMP:  begin s = k; k++; end
            MODE_CONST: s = -1000;
            default:    s = int'($urandom_range(2000)) - 1000;
        endcase
        sin_in = W'(s);
        sym_in = sy;
        sym_valid = v;
        @(posedge Clk);
        acc = 1'b0;
        smp = 1'b0;
        used = m_sym;
        if (!Rst_n) begin
            m_fill = QDELAY; m_run = 1'b0; m_left = 0;
            m_ready = 1'b0; m_underrun = 1'b0;
            hist.delete();
        end else begin
            qc = (hist.size() == QDELAY) ? hist[0] : 0;
            m_underrun = 1'b0;
            if (m_fill > 0) begin
                m_fill--;
            end else if (!m_run) begin
                if (v) begin m_run = 1'b1; m_left = SPS; m_sym = sy; acc = 1'b1; end
            end else begin
                smp = 1'b1;
                exp_q.push_back(exp_mod(m_sym, qc, s));
                if (m_left == 1) begin
                    if (v) begin m_sym = sy; m_left = SPS; acc = 1'b1; end
                    else begin m_run = 1'b0; m_underrun = 1'b1; end
                end else begin
                    m_left--;
                end
            end
            hist.push_back(s);
            if (hist.size() > QDELAY) hist.pop_front();
            m_ready = (m_fill == 0 && !m_run) || (m_run && m_left == 1);
        end
        #1;
    endtask

    task automatic do_reset();
        logic a, sm;
        logic [1:0] u;
        int s;
        Rst_n = 1'b0;
        tick(2'b00, 1'b0, a, sm, u, s);
        tick(2'b00, 1'b0, a, sm, u, s);
        Rst_n = 1'b1;
        k = 0;
        for (int n = 0; n < 4*QDELAY && !m_ready; n++) tick(2'b00, 1'b0, a, sm, u, s);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge Clk) begin : monitor
        logic signed [W:0] e;
        if (mon_en) begin
            n_cmp++;
            if (mod_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sample_unexpected: mod_valid=%b mod_out=%0d, required mod_valid=0", mod_valid, mod_out);
                end else begin
                    e = exp_q.pop_front();
                    if (mod_out !== e) begin
                        n_fail++;
                        $display("FAIL mod_out: got %0d, required %0d at %0t", mod_out, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_fail++;
                $display("FAIL sample_missing: mod_valid=%b, required 1 with mod_out=%0d", mod_valid, e);
            end else if (mod_out !== '0) begin
                n_fail++;
                $display("FAIL idle_mod_out: got %0d, required 0", mod_out);
            end
            n_cmp++;
            if (sym_ready !== m_ready) begin
                n_fail++;
                $display("FAIL sym_ready: got %b, required %b at %0t", sym_ready, m_ready, $time);
            end
            n_cmp++;
            if (underrun !== m_underrun) begin
                n_fail++;
                $display("FAIL underrun: got %b, required %b at %0t", underrun, m_underrun, $time);
            end
        end
    end

    task automatic test_reset();
        logic a, sm;
        logic [1:0] u;
        int s;
        int n;
        mode = MODE_RAND;
        Rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(2'($urandom_range(3)), 1'($urandom_range(1)), a, sm, u, s);
            mon_en = 1'b1;
            n_cmp++;
            if (mod_out !== '0 || mod_valid !== 1'b0 || sym_ready !== 1'b0 || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got out=%0d valid=%b ready=%b underrun=%b, required all 0",
                         mod_out, mod_valid, sym_ready, underrun);
            end
        end
        Rst_n = 1'b1;
        n = 0;
        while (sym_ready !== 1'b1 && n < 4*QDELAY) begin
            n++;
            tick(2'b00, 1'b0, a, sm, u, s);
        end
        n_cmp++;
        if (n != QDELAY) begin
            n_fail++;
            $display("FAIL fill_length: sym_ready low for %0d cycles, required %0d", n, QDELAY);
        end
    endtask

    task automatic test_ramp();
        logic a, sm;
        logic [1:0] u;
        int s, e, got, idx, n_smp;
        logic [1:0] syms [4];
        syms = '{2'b00, 2'b11, 2'b01, 2'b10};
        mode = MODE_RAMP;
        do_reset();
        idx = 0;
        n_smp = 0;
        for (int n = 0; n < SPS*5; n++) begin
            if (idx < 4) tick(syms[idx], 1'b1, a, sm, u, s);
            else tick(2'b00, 1'b0, a, sm, u, s);
            if (a) idx++;
            if (sm) begin
                n_smp++;
                case (u)
                    2'b00:   e = 2*s - QDELAY;
                    2'b11:   e = -(2*s - QDELAY);
                    2'b01:   e = -QDELAY;
                    default: e = QDELAY;
                endcase
                got = int'(mod_out);
                n_cmp++;
                if (got != e || mod_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ramp_sym%b: k=%0d got %0d valid=%b, required %0d", u, s, got, mod_valid, e);
                end
            end
        end
        n_cmp++;
        if (n_smp != 4*SPS) begin
            n_fail++;
            $display("FAIL ramp_samples: got %0d, required %0d", n_smp, 4*SPS);
        end
    endtask

    task automatic test_full_scale();
        logic a, sm;
        logic [1:0] u;
        int s, e, idx;
        logic [1:0] syms [2];
        syms = '{2'b00, 2'b11};
        mode = MODE_CONST;
        do_reset();
        idx = 0;
        for (int n = 0; n < SPS*3; n++) begin
            if (idx < 2) tick(syms[idx], 1'b1, a, sm, u, s);
            else tick(2'b00, 1'b0, a, sm, u, s);
            if (a) idx++;
            if (sm) begin
                e = (u == 2'b00) ? -2000 : 2000;
                n_cmp++;
                if (int'(mod_out) != e) begin
                    n_fail++;
                    $display("FAIL full_scale_sym%b: got %0d, required %0d", u, mod_out, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic a, sm;
        logic [1:0] u;
        int s, idx, nr, cur, max_run, n_und;
        int rdy_t [4];
        logic [1:0] syms [3];
        syms = '{2'b00, 2'b11, 2'b01};
        mode = MODE_RAND;
        do_reset();
        idx = 0; nr = 0; cur = 0; max_run = 0; n_und = 0;
        rdy_t = '{0, 0, 0, 0};
        for (int n = 0; n < SPS*4; n++) begin
            if (sym_ready === 1'b1 && nr < 4) begin rdy_t[nr] = n; nr++; end
            if (idx < 3) tick(syms[idx], 1'b1, a, sm, u, s);
            else tick(2'b00, 1'b0, a, sm, u, s);
            if (a) idx++;
            if (mod_valid === 1'b1) begin
                cur++;
                if (cur > max_run) max_run = cur;
            end else begin
                cur = 0;
            end
            if (underrun === 1'b1) n_und++;
        end
        n_cmp++;
        if (max_run != 3*SPS) begin
            n_fail++;
            $display("FAIL b2b_continuous: longest mod_valid run %0d, required %0d", max_run, 3*SPS);
        end
        n_cmp++;
        if (nr != 4 || rdy_t[1]-rdy_t[0] != SPS || rdy_t[2]-rdy_t[1] != SPS || rdy_t[3]-rdy_t[2] != SPS) begin
            n_fail++;
            $display("FAIL b2b_ready_spacing: ready at %0d %0d %0d %0d (count %0d), required spacing %0d",
                     rdy_t[0], rdy_t[1], rdy_t[2], rdy_t[3], nr, SPS);
        end
        n_cmp++;
        if (n_und != 1) begin
            n_fail++;
            $display("FAIL b2b_underrun_count: got %0d, required 1", n_und);
        end
    endtask

    task automatic test_underrun();
        logic a, sm;
        logic [1:0] u;
        int s, n_und;
        logic prev_und;
        mode = MODE_RAMP;
        do_reset();
        a = 1'b0;
        for (int n = 0; n < 10 && !a; n++) tick(2'b01, 1'b1, a, sm, u, s);
        n_und = 0;
        prev_und = 1'b0;
        for (int n = 0; n < SPS+5; n++) begin
            tick(2'b00, 1'b0, a, sm, u, s);
            if (prev_und) begin
                n_cmp++;
                if (mod_valid !== 1'b0 || mod_out !== '0 || sym_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL after_underrun: valid=%b out=%0d ready=%b, required 0/0/1", mod_valid, mod_out, sym_ready);
                end
            end
            prev_und = (underrun === 1'b1);
            if (prev_und) n_und++;
        end
        n_cmp++;
        if (n_und != 1) begin
            n_fail++;
            $display("FAIL underrun_width: high for %0d cycles, required 1", n_und);
        end
        tick(2'b10, 1'b1, a, sm, u, s);
        n_cmp++;
        if (mod_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_handshake: mod_valid=%b on handshake edge, required 0", mod_valid);
        end
        tick(2'b00, 1'b0, a, sm, u, s);
        n_cmp++;
        if (mod_valid !== 1'b1 || int'(mod_out) != QDELAY) begin
            n_fail++;
            $display("FAIL resume_first_sample: valid=%b out=%0d, required 1/%0d", mod_valid, mod_out, QDELAY);
        end
        for (int n = 0; n < SPS+2; n++) tick(2'b00, 1'b0, a, sm, u, s);
    endtask

    task automatic test_reset_mid_run();
        logic a, sm;
        logic [1:0] u;
        int s, n;
        mode = MODE_RAND;
        do_reset();
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) tick(2'b11, 1'b1, a, sm, u, s);
        for (int i = 0; i < 50; i++) tick(2'b00, 1'b0, a, sm, u, s);
        Rst_n = 1'b0;
        tick(2'b00, 1'b1, a, sm, u, s);
        n_cmp++;
        if (mod_valid !== 1'b0 || mod_out !== '0 || sym_ready !== 1'b0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: valid=%b out=%0d ready=%b underrun=%b, required all 0",
                     mod_valid, mod_out, sym_ready, underrun);
        end
        Rst_n = 1'b1;
        n = 0;
        while (sym_ready !== 1'b1 && n < 4*QDELAY) begin
            n++;
            tick(2'b00, 1'b1, a, sm, u, s);
        end
        n_cmp++;
        if (n != QDELAY) begin
            n_fail++;
            $display("FAIL mid_reset_refill: sym_ready low for %0d cycles, required %0d", n, QDELAY);
        end
        for (int i = 0; i < SPS+3; i++) tick(2'b00, 1'b0, a, sm, u, s);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_full_scale();
        test_back_to_back();
        test_underrun();
        test_reset_mid_run();
        @(negedge Clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d samples still expected, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, required completion within 2000000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
